wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
Write-back end of the 5-stage pipeline. Consumes the latched MEM/WB outputs (RegWrite, MemtoReg, ReadData, ALU result, rd) and selects the write-back value. Commits that value into the 32x64 integer register file and serves the two ID-stage read ports plus one debug port. Provides same-cycle write-to-read bypass, a written-register bitmap, and a write-back commit counter for the sorting testbenches.

Parameters:
XLEN, 64, data width of every register and data port
NREGS, 32, number of architectural registers; index width = 5
CNT_W, 32, width of the commit counter

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
RegWrite  input  1  write enable from the MEM/WB stage
MemtoReg  input  1  1 = write ReadData, 0 = write ALU_result
ReadData  input  XLEN  load data from the MEM/WB stage
ALU_result  input  XLEN  ALU result from the MEM/WB stage
rd  input  5  destination register index
rs1  input  5  read port 1 address (ID stage)
rs2  input  5  read port 2 address (ID stage)
dbg_addr  input  5  debug read address
ReadData1  output  XLEN  read port 1 data
ReadData2  output  XLEN  read port 2 data
dbg_data  output  XLEN  debug read data, registered
wb_data  output  XLEN  selected write-back value, combinational
written_map  output  NREGS  bit i set once register i has been written since reset
commit_count  output  CNT_W  number of committed register writes since reset

Behaviour:
- Reset: synchronous and active-high, sampled on the rising edge of clk.
  - All registers clear to 0.
  - written_map, commit_count and dbg_data clear to 0.
  - Reset wins over a simultaneous write; the write is dropped.
- Write-back select: wb_data = MemtoReg ? ReadData : ALU_result. Combinational, always driven, including when RegWrite = 0.
- Commit: a write is effective when RegWrite = 1 and rd != 0 and reset = 0.
  - On that rising edge, regs[rd] <= wb_data.
  - written_map[rd] <= 1.
  - commit_count <= commit_count + 1, wrapping modulo 2^CNT_W with no saturation.
- x0:
  - Writes to rd = 0 are ignored; they do not update the count or the map.
  - written_map[0] stays 0.
  - Any read of address 0 returns 0.
- Read ports 1 and 2 are combinational, with zero-cycle latency.
  - If an effective write is present and rsN == rd, ReadDataN = wb_data (write-through bypass).
  - Otherwise ReadDataN = regs[rsN].
  - Both ports may read the same address in the same cycle.
- Debug port is registered, with one-cycle latency.
  - dbg_data <= regs[dbg_addr] as sampled at the edge: it returns the pre-write value, with no bypass.
  - Address 0 gives 0.
- There is no handshake: the block accepts one write per cycle unconditionally, with no back-pressure.
- Reset asserted mid-sequence: all contents are lost and counting restarts from 0 on the first effective write after reset deasserts.

Decomposition:
- Shared package (riscv_pkg) holds:
  - XLEN and the register-index width constant (5).
  - A localparam for the zero register index.
  - The writeback-select encoding: WB_ALU = 0, WB_MEM = 1.
- One natural sub-module, wb_mux: the XLEN-wide MemtoReg select.
- Storage, bypass, map and counter live in wb_regfile.

Test Plan:
1. Reset behaviour: assert reset 2 cycles, then read rs1=5, rs2=31, and the debug port at 7 -> all data 0, written_map = 0, commit_count = 0.
2. Write select and bypass:
   - RegWrite=1, MemtoReg=0, ALU_result=64'h1234, rd=3, with rs1=3 in the same cycle -> ReadData1 = 64'h1234 before the edge (bypass).
   - Next cycle, MemtoReg=1, ReadData=64'hDEAD, rd=3 -> regs[3] = 64'hDEAD and commit_count = 2.
3. x0 protection: RegWrite=1, rd=0, ALU_result=64'hFFFF, rs1=0 -> ReadData1 = 0, commit_count unchanged, written_map[0] = 0.
4. Gated write: RegWrite=0, rd=9, ALU_result=64'h55 -> regs[9] stays 0, written_map[9] = 0, wb_data = 64'h55.
5. Reset priority: reset=1 together with a write of 64'hAA to rd=4 -> regs[4] = 0, commit_count = 0.
   - Then write rd=4 after reset deasserts -> commit_count = 1, written_map = 32'h10.
6. Debug latency and wrap:
   - Write 64'h77 to rd=10 while dbg_addr=10 -> dbg_data shows the old value 0 on that edge and 64'h77 one cycle later.
   - With CNT_W=4, perform 17 writes -> commit_count = 1.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared widths, register-index constants and the write-back
//               select encoding for the RISC-V pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN      = 64;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_sel_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/wb_mux.sv
`default_nettype none
// ============================================================================
// Module      : wb_mux
// Description : Write-back value select between load data and ALU result.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mux
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_mem_data,
    input  logic [WIDTH-1:0] i_alu_data,
    output logic [WIDTH-1:0] o_wb_data
);

    wb_sel_e w_sel;

    assign w_sel     = wb_sel_e'(i_sel);
    assign o_wb_data = (w_sel == WB_MEM) ? i_mem_data : i_alu_data;

endmodule : wb_mux
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Write-back stage and 32xXLEN integer register file with
//               write-through bypass, written-register map and commit count.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RegWrite,
    input  logic                 MemtoReg,
    input  logic [XLEN-1:0]      ReadData,
    input  logic [XLEN-1:0]      ALU_result,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    output logic [XLEN-1:0]      ReadData1,
    output logic [XLEN-1:0]      ReadData2,
    output logic [XLEN-1:0]      dbg_data,
    output logic [XLEN-1:0]      wb_data,
    output logic [NREGS-1:0]     written_map,
    output logic [CNT_W-1:0]     commit_count
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_written_map;
    logic [CNT_W-1:0] r_commit_count;
    logic [XLEN-1:0]  r_dbg_data;

    logic [XLEN-1:0]  w_wb_data;
    logic             w_wr_en;
    logic [XLEN-1:0]  w_rd1;
    logic [XLEN-1:0]  w_rd2;

    wb_mux #(
        .WIDTH      (XLEN)
    ) u_wb_mux (
        .i_sel      (MemtoReg),
        .i_mem_data (ReadData),
        .i_alu_data (ALU_result),
        .o_wb_data  (w_wb_data)
    );

    // x0 is hard-wired, and a write coinciding with reset is dropped.
    assign w_wr_en = RegWrite && (rd != REG_ZERO) && !reset;

    always_comb begin
        w_rd1 = '0;
        if (rs1 != REG_ZERO) begin
            if (w_wr_en && (rs1 == rd)) begin
                w_rd1 = w_wb_data;
            end else begin
                w_rd1 = r_regs[rs1];
            end
        end
    end

    always_comb begin
        w_rd2 = '0;
        if (rs2 != REG_ZERO) begin
            if (w_wr_en && (rs2 == rd)) begin
                w_rd2 = w_wb_data;
            end else begin
                w_rd2 = r_regs[rs2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[rd] <= w_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_written_map  <= '0;
            r_commit_count <= '0;
        end else if (w_wr_en) begin
            r_written_map[rd] <= 1'b1;
            r_commit_count    <= r_commit_count + 1'b1;
        end
    end

    // Debug port samples storage before this edge's write lands: no bypass.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dbg_data <= '0;
        end else if (dbg_addr == REG_ZERO) begin
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= r_regs[dbg_addr];
        end
    end

    assign wb_data      = w_wb_data;
    assign ReadData1    = w_rd1;
    assign ReadData2    = w_rd2;
    assign dbg_data     = r_dbg_data;
    assign written_map  = r_written_map;
    assign commit_count = r_commit_count;

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Directed self-checking bench for wb_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic        MemtoReg;
    logic [63:0] ReadData;
    logic [63:0] ALU_result;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  dbg_addr;

    logic [63:0] w_rd1, w_rd2, w_dbg, w_wb;
    logic [31:0] w_map;
    logic [31:0] w_cnt;

    logic [63:0] w4_rd1, w4_rd2, w4_dbg, w4_wb;
    logic [31:0] w4_map;
    logic [3:0]  w4_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    wb_regfile #(.XLEN(64), .NREGS(32), .CNT_W(32)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .RegWrite     (RegWrite),
        .MemtoReg     (MemtoReg),
        .ReadData     (ReadData),
        .ALU_result   (ALU_result),
        .rd           (rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .dbg_addr     (dbg_addr),
        .ReadData1    (w_rd1),
        .ReadData2    (w_rd2),
        .dbg_data     (w_dbg),
        .wb_data      (w_wb),
        .written_map  (w_map),
        .commit_count (w_cnt)
    );

    // Narrow-counter instance shares all stimulus, used for the wrap check.
    wb_regfile #(.XLEN(64), .NREGS(32), .CNT_W(4)) u_dut4 (
        .clk          (clk),
        .reset        (reset),
        .RegWrite     (RegWrite),
        .MemtoReg     (MemtoReg),
        .ReadData     (ReadData),
        .ALU_result   (ALU_result),
        .rd           (rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .dbg_addr     (dbg_addr),
        .ReadData1    (w4_rd1),
        .ReadData2    (w4_rd2),
        .dbg_data     (w4_dbg),
        .wb_data      (w4_wb),
        .written_map  (w4_map),
        .commit_count (w4_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        ReadData   = '0;
        ALU_result = '0;
        rd         = '0;
        rs1        = 5'd5;
        rs2        = 5'd31;
        dbg_addr   = 5'd7;
        tick();
        tick();

        // Reset state
        reset = 1'b0;
        #1;
        chk("rst_rd1", w_rd1, 64'h0);
        chk("rst_rd2", w_rd2, 64'h0);
        chk("rst_dbg", w_dbg, 64'h0);
        chk("rst_map", {32'h0, w_map}, 64'h0);
        chk("rst_cnt", {32'h0, w_cnt}, 64'h0);
        tick();
        chk("rst_dbg2", w_dbg, 64'h0);

        // ALU write with same-cycle bypass
        RegWrite = 1'b1; MemtoReg = 1'b0; ALU_result = 64'h1234; rd = 5'd3; rs1 = 5'd3;
        #1;
        chk("byp_alu_rd1", w_rd1, 64'h1234);
        chk("byp_alu_wb", w_wb, 64'h1234);
        tick();
        chk("cnt_after1", {32'h0, w_cnt}, 64'd1);

        // Load-data write to the same register
        MemtoReg = 1'b1; ReadData = 64'hDEAD;
        #1;
        chk("byp_mem_rd1", w_rd1, 64'hDEAD);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("reg3_mem", w_rd1, 64'hDEAD);
        chk("cnt_after2", {32'h0, w_cnt}, 64'd2);
        chk("map_r3", {32'h0, w_map}, 64'h8);

        // x0 protection
        RegWrite = 1'b1; MemtoReg = 1'b0; ALU_result = 64'hFFFF; rd = 5'd0; rs1 = 5'd0;
        #1;
        chk("x0_rd1", w_rd1, 64'h0);
        chk("x0_wb", w_wb, 64'hFFFF);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("x0_rd1_after", w_rd1, 64'h0);
        chk("x0_cnt", {32'h0, w_cnt}, 64'd2);
        chk("x0_map", {32'h0, w_map}, 64'h8);

        // Gated write
        ALU_result = 64'h55; rd = 5'd9; rs2 = 5'd9;
        #1;
        chk("gate_wb", w_wb, 64'h55);
        chk("gate_rd2_comb", w_rd2, 64'h0);
        tick();
        chk("gate_rd2", w_rd2, 64'h0);
        chk("gate_map", {32'h0, w_map}, 64'h8);

        // Reset wins over a simultaneous write
        reset = 1'b1; RegWrite = 1'b1; ALU_result = 64'hAA; rd = 5'd4; rs1 = 5'd4; rs2 = 5'd3;
        tick();
        reset = 1'b0; RegWrite = 1'b0;
        #1;
        chk("rstpri_rd1", w_rd1, 64'h0);
        chk("rstpri_r3", w_rd2, 64'h0);
        chk("rstpri_cnt", {32'h0, w_cnt}, 64'd0);
        chk("rstpri_map", {32'h0, w_map}, 64'h0);
        RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0; rs2 = 5'd4;
        #1;
        chk("post_rst_cnt", {32'h0, w_cnt}, 64'd1);
        chk("post_rst_map", {32'h0, w_map}, 64'h10);
        chk("dual_rd1", w_rd1, 64'hAA);
        chk("dual_rd2", w_rd2, 64'hAA);

        // Debug port returns pre-write value, then the new one a cycle later
        RegWrite = 1'b1; ALU_result = 64'h77; rd = 5'd10; dbg_addr = 5'd10;
        tick();
        RegWrite = 1'b0;
        #1;
        chk("dbg_old", w_dbg, 64'h0);
        tick();
        chk("dbg_new", w_dbg, 64'h77);
        dbg_addr = 5'd0;
        tick();
        chk("dbg_x0", w_dbg, 64'h0);

        // Commit counter wrap on the 4-bit instance
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("wrap_rst_cnt", {60'h0, w4_cnt}, 64'd0);
        RegWrite = 1'b1; MemtoReg = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            rd = 5'(i); ALU_result = 64'(i);
            tick();
        end
        #1;
        chk("wrap16_cnt4", {60'h0, w4_cnt}, 64'd0);
        rd = 5'd17; ALU_result = 64'd17;
        tick();
        RegWrite = 1'b0;
        #1;
        chk("wrap17_cnt4", {60'h0, w4_cnt}, 64'd1);
        chk("wrap17_cnt32", {32'h0, w_cnt}, 64'd17);
        chk("wrap17_map", {32'h0, w_map}, 64'h0003_FFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_wb_regfile
`default_nettype wire
